// File: rtl/rr_bus_arbiter_if.sv
// Requester/downstream bundle for the round-robin bus arbiter.
// master = arbiter side, slave = requesters plus downstream consumer.
interface rr_bus_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             out_ready;
  logic [3:0]       gnt;
  logic [3:0]       en;
  logic [1:0]       sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;

  modport master (
    input  req, d0, d1, d2, d3, out_ready,
    output gnt, en, sel, q, q_valid
  );

  modport slave (
    output req, d0, d1, d2, d3, out_ready,
    input  gnt, en, sel, q, q_valid
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Four-way round-robin arbiter with bounded grant length, driving mux select,
// tristate enables and a registered valid/ready output word.
module rr_bus_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  rr_bus_arbiter_if.master bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_q_valid, w_q_valid_nxt;

  logic             w_acc;
  logic             w_own_req;
  logic             w_xfer;
  logic             w_release;
  logic [1:0]       w_scan_ptr;
  logic [2:0]       w_pick;
  logic [WIDTH-1:0] w_d_sel;

  // Returns {found, index} of the first requester at or after ptr (mod 4).
  function automatic logic [2:0] pick_winner(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    unique case (r_sel)
      2'd0:    w_d_sel = bus.d0;
      2'd1:    w_d_sel = bus.d1;
      2'd2:    w_d_sel = bus.d2;
      default: w_d_sel = bus.d3;
    endcase
  end

  assign w_acc      = !r_q_valid || bus.out_ready;
  assign w_own_req  = bus.req[r_sel];
  assign w_xfer     = (r_state == ST_GRANT) && w_own_req && w_acc;
  // Owner drop releases even under backpressure; the hold limit only on a real transfer.
  assign w_release  = (r_state == ST_GRANT) &&
                      (!w_own_req || (w_xfer && (r_cnt == LAST_CNT)));
  assign w_scan_ptr = w_release ? (r_sel + 2'd1) : r_ptr;
  assign w_pick     = pick_winner(bus.req, w_scan_ptr);

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_q_nxt       = r_q;
    w_q_valid_nxt = r_q_valid;

    if (w_xfer) begin
      w_q_nxt       = w_d_sel;
      w_q_valid_nxt = 1'b1;
      w_cnt_nxt     = r_cnt + CNT_W'(1);
    end else if (bus.out_ready && r_q_valid) begin
      w_q_valid_nxt = 1'b0;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'b0001 << w_pick[1:0];
          w_sel_nxt   = w_pick[1:0];
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (w_release) begin
          w_ptr_nxt = w_scan_ptr;
          if (w_pick[2]) begin
            w_gnt_nxt = 4'b0001 << w_pick[1:0];
            w_sel_nxt = w_pick[1:0];
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.en      = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: vector table, corner-case sequences and a random
// run against a queue-free behavioural model, on MAX_HOLD=4 and MAX_HOLD=1 instances.
module tb_rr_bus_arbiter;
  localparam int unsigned W    = 4;
  localparam int          MH_A = 4;
  localparam int          MH_B = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [W-1:0] d [4];
  logic         out_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  rr_bus_arbiter_if #(.WIDTH(W)) bus_a ();
  rr_bus_arbiter_if #(.WIDTH(W)) bus_b ();

  assign bus_a.req = req;  assign bus_a.out_ready = out_ready;
  assign bus_a.d0 = d[0];  assign bus_a.d1 = d[1];
  assign bus_a.d2 = d[2];  assign bus_a.d3 = d[3];
  assign bus_b.req = req;  assign bus_b.out_ready = out_ready;
  assign bus_b.d0 = d[0];  assign bus_b.d1 = d[1];
  assign bus_b.d2 = d[2];  assign bus_b.d3 = d[3];

  rr_bus_arbiter #(.WIDTH(W), .MAX_HOLD(MH_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  rr_bus_arbiter #(.WIDTH(W), .MAX_HOLD(MH_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = idle), priority pointer, words taken this grant.
  typedef struct {
    int owner;
    int ptr;
    int cnt;
    int sel;
    int q;
    bit qv;
  } model_t;
  model_t m [2];
  int     mh [2] = '{MH_A, MH_B};

  typedef struct {
    logic [3:0]   req;
    logic [W-1:0] d2;
    logic         rdy;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] q;
    logic         qv;
  } vec_t;
  vec_t tbl [7];

  function automatic int pick_m(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (r[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) m[k] = '{owner: -1, ptr: 0, cnt: 0, sel: 0, q: 0, qv: 1'b0};
  endfunction

  function automatic void model_step(input int k);
    bit acc, own, xfer, rel;
    int w;
    acc = !m[k].qv || out_ready;
    if (m[k].owner < 0) begin
      if (out_ready && m[k].qv) m[k].qv = 1'b0;
      w = pick_m(req, m[k].ptr);
      if (w >= 0) begin m[k].owner = w; m[k].sel = w; m[k].cnt = 0; end
    end else begin
      own  = req[m[k].owner];
      xfer = own && acc;
      if (xfer) begin
        m[k].q  = int'(d[m[k].owner]);
        m[k].qv = 1'b1;
        m[k].cnt++;
      end else if (out_ready && m[k].qv) begin
        m[k].qv = 1'b0;
      end
      rel = !own || (xfer && m[k].cnt == mh[k]);
      if (rel) begin
        m[k].ptr = (m[k].owner + 1) % 4;
        w = pick_m(req, m[k].ptr);
        if (w >= 0) begin m[k].owner = w; m[k].sel = w; m[k].cnt = 0; end
        else m[k].owner = -1;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inv(input string tag, input logic [3:0] g, input logic [3:0] e,
                           input logic [1:0] s);
    check({tag, "_onehot0"}, int'($onehot0(g)), 1);
    check({tag, "_en_eq_gnt"}, int'(e), int'(g));
    if (g != 4'b0000) check({tag, "_en_sel"}, int'(g), int'(4'b0001 << s));
  endtask

  task automatic cmp_model(input int k, input logic [3:0] g, input logic [3:0] e,
                           input logic [1:0] s, input logic [W-1:0] qo, input logic qv);
    string tag;
    int    exp_g;
    tag   = $sformatf("rand%0d", k);
    exp_g = (m[k].owner < 0) ? 0 : (1 << m[k].owner);
    check({tag, "_gnt"}, int'(g), exp_g);
    check({tag, "_sel"}, int'(s), m[k].sel);
    check({tag, "_q"}, int'(qo), m[k].q);
    check({tag, "_qv"}, int'(qv), int'(m[k].qv));
    check_inv(tag, g, e, s);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_d(input int a, input int b, input int c, input int e);
    d[0] = W'(a); d[1] = W'(b); d[2] = W'(c); d[3] = W'(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0100, 4'hA, 1'b1, 4'b0100, 2'd2, 4'h0, 1'b0};
    tbl[1] = '{4'b0100, 4'hA, 1'b1, 4'b0100, 2'd2, 4'hA, 1'b1};
    tbl[2] = '{4'b0100, 4'hB, 1'b1, 4'b0100, 2'd2, 4'hB, 1'b1};
    tbl[3] = '{4'b0100, 4'hC, 1'b1, 4'b0100, 2'd2, 4'hC, 1'b1};
    tbl[4] = '{4'b0100, 4'hD, 1'b1, 4'b0100, 2'd2, 4'hD, 1'b1};
    tbl[5] = '{4'b0100, 4'hE, 1'b1, 4'b0100, 2'd2, 4'hE, 1'b1};
    tbl[6] = '{4'b0000, 4'hF, 1'b1, 4'b0000, 2'd2, 4'hE, 1'b0};

    set_d(1, 2, 3, 4);
    model_reset();
    @(posedge clk); #1;
    check("rst_gnt", int'(bus_a.gnt), 0);
    check("rst_en", int'(bus_a.en), 0);
    check("rst_sel", int'(bus_a.sel), 0);
    check("rst_q", int'(bus_a.q), 0);
    check("rst_qv", int'(bus_a.q_valid), 0);
    rst_n = 1'b1;

    // Single requester: grant latency, data latency, re-grant with no bubble, idle.
    do_reset();
    set_d(1, 2, 0, 3);
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req; d[2] = tbl[i].d2; out_ready = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d_gnt", i), int'(bus_a.gnt), int'(tbl[i].gnt));
      check($sformatf("vec%0d_en", i), int'(bus_a.en), int'(tbl[i].gnt));
      check($sformatf("vec%0d_sel", i), int'(bus_a.sel), int'(tbl[i].sel));
      check($sformatf("vec%0d_q", i), int'(bus_a.q), int'(tbl[i].q));
      check($sformatf("vec%0d_qv", i), int'(bus_a.q_valid), int'(tbl[i].qv));
    end

    // Round robin with MAX_HOLD=1.
    do_reset();
    req = 4'b1111; out_ready = 1'b1; set_d(1, 2, 3, 4);
    tick();
    check("rr_first_sel", int'(bus_b.sel), 0);
    check("rr_first_gnt", int'(bus_b.gnt), 1);
    for (int j = 1; j <= 5; j++) begin
      tick();
      check($sformatf("rr%0d_sel", j), int'(bus_b.sel), j % 4);
      check($sformatf("rr%0d_gnt", j), int'(bus_b.gnt), 1 << (j % 4));
      check($sformatf("rr%0d_q", j), int'(bus_b.q), ((j - 1) % 4) + 1);
      check($sformatf("rr%0d_qv", j), int'(bus_b.q_valid), 1);
    end

    // Hold limit: requester 0 gets four words, then requester 1.
    do_reset();
    req = 4'b0011; set_d(7, 9, 0, 0);
    tick();
    check("hold_gnt0", int'(bus_a.gnt), 1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check($sformatf("hold%0d_q", j), int'(bus_a.q), 7);
      check($sformatf("hold%0d_gnt", j), int'(bus_a.gnt), (j < 4) ? 1 : 2);
    end
    tick();
    check("hold_next_q", int'(bus_a.q), 9);
    check("hold_next_gnt", int'(bus_a.gnt), 2);

    // Backpressure: output frozen, d change ignored, grant total still four.
    do_reset();
    req = 4'b0011; set_d(5, 9, 0, 0); out_ready = 1'b1;
    tick();
    tick();
    check("bp_first_q", int'(bus_a.q), 5);
    out_ready = 1'b0; d[0] = W'(6);
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("bp%0d_q", j), int'(bus_a.q), 5);
      check($sformatf("bp%0d_qv", j), int'(bus_a.q_valid), 1);
      check($sformatf("bp%0d_gnt", j), int'(bus_a.gnt), 1);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("bp_resume%0d_q", j), int'(bus_a.q), 6);
      check($sformatf("bp_resume%0d_gnt", j), int'(bus_a.gnt), (j < 2) ? 1 : 2);
    end
    tick();
    check("bp_next_q", int'(bus_a.q), 9);

    // Owner drop mid-burst hands over on the same edge.
    do_reset();
    req = 4'b1010; set_d(0, 3, 0, 12); out_ready = 1'b1;
    tick();
    check("drop_gnt0", int'(bus_a.gnt), 2);
    tick();
    check("drop_q0", int'(bus_a.q), 3);
    req = 4'b1000; d[1] = W'(4);
    tick();
    check("drop_gnt", int'(bus_a.gnt), 8);
    check("drop_sel", int'(bus_a.sel), 3);
    check("drop_q", int'(bus_a.q), 3);
    check("drop_qv", int'(bus_a.q_valid), 0);
    tick();
    check("drop_q3", int'(bus_a.q), 12);
    check("drop_gnt3", int'(bus_a.gnt), 8);

    // Async reset between edges.
    do_reset();
    req = 4'b1111; set_d(1, 2, 3, 4);
    tick();
    tick();
    check("ar_pre_qv", int'(bus_a.q_valid), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_gnt", int'(bus_a.gnt), 0);
    check("ar_en", int'(bus_a.en), 0);
    check("ar_qv", int'(bus_a.q_valid), 0);
    check("ar_gnt_b", int'(bus_b.gnt), 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_after_gnt", int'(bus_a.gnt), 1);
    check("ar_after_sel", int'(bus_a.sel), 0);

    // Random traffic against the model on both instances.
    do_reset();
    req = 4'b0000;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) d[i] = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cmp_model(0, bus_a.gnt, bus_a.en, bus_a.sel, bus_a.q, bus_a.q_valid);
      cmp_model(1, bus_b.gnt, bus_b.en, bus_b.sel, bus_b.q, bus_b.q_valid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter and output register stage upstream of the 4:1 4-bit select muxes and tristate bus drivers.
- Chooses one of four requesters and drives `sel[1:0]` to the mux select and one-hot `en[3:0]` to the tristate enables.
- Registers the selected data word and presents it downstream with a valid/ready handshake.
- Bounds each grant to MAX_HOLD transfers so that no requester can starve the others.

Parameters:
- WIDTH, 4, data width of each requester word and of `q`.
- MAX_HOLD, 4, maximum transfers per grant; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  4  per-requester request; `req[i]` is high while requester i has data on `d[i]`.
- `d0`, `d1`, `d2`, `d3`  in  WIDTH each  requester data words.
- `out_ready`  in  1  downstream can accept `q` this cycle.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `en`  out  4  tristate enables, identical to `gnt`.
- `sel`  out  2  binary index of granted requester, registered.
- `q`  out  WIDTH  registered data word.
- `q_valid`  out  1  `q` holds a word not yet accepted.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE, `gnt`=0, `en`=0, `sel`=0, `q`=0, `q_valid`=0.
  - Priority pointer ptr=0; hold counter cnt=0.
- Winner selection:
  - First i with `req[i]`=1, scanning ptr, ptr+1, ... mod 4.
  - Combinational, from the current req and ptr.
- IDLE:
  - If any `req` is high, next edge: state=GRANT, `gnt`=onehot(winner), `sel`=winner, cnt=0.
  - Grant latency is one cycle from req.
  - `sel` holds its last value while idle; `gnt`=`en`=0.
- Accept condition: `acc` = `q_valid`=0 or `out_ready`=1.
- Transfer, in GRANT, occurs when `req[sel]`=1 and `acc`:
  - `q` <= `d[sel]`, `q_valid` <= 1, cnt <= cnt+1.
- Output drain: if `out_ready`=1 and `q_valid`=1 with no transfer that cycle, `q_valid` <= 0 and `q` holds.
- Backpressure: while `q_valid`=1 and `out_ready`=0:
  - no transfer; cnt frozen; grant held.
  - `q` and `q_valid` are stable.
- Release: a GRANT cycle is a release cycle when either condition holds:
  - (a) `req[sel]`=0 — no transfer that cycle; or
  - (b) a transfer occurs with cnt=MAX_HOLD-1 — the MAX_HOLD-th word is taken that cycle.
- On a release cycle:
  - ptr <= sel+1 mod 4.
  - Winner is recomputed using the new ptr and the current req.
  - If any req is high, stay in GRANT with the new owner and cnt=0; no idle bubble. The old owner can win again only if it is the sole requester.
  - Otherwise go to IDLE and set `gnt`=0.
- A release caused by the owner dropping `req` is honoured even under backpressure.
- Invariants:
  - `gnt`/`en` are always zero or one-hot.
  - `en[i]`=1 implies `sel`=i.
  - No two enables are ever high together, so there is no tristate contention.
- Data is sampled only on a transfer; changes on a non-granted `d[i]` never affect `q`.
- Width: cnt is 4 bits; ptr is 2 bits with natural wrap 3->0.

Test Plan:
- Single requester:
  - Stimulus: `req`=0100, `d2`=4'hA, `out_ready`=1.
  - Required: cycle 1 `gnt`=0100, `sel`=2, `en`=0100; cycle 2 `q`=A, `q_valid`=1.
  - After 4 transfers, re-grant to requester 2 with no bubble.
- Round robin:
  - Stimulus: `req`=1111 held, MAX_HOLD=1, `out_ready`=1.
  - Required: `sel` sequence 0,1,2,3,0 with one word each and no idle cycles.
- Hold limit:
  - Stimulus: `req`=0011, MAX_HOLD=4, `out_ready`=1.
  - Required: requester 0 gets exactly 4 transfers (`q`=`d0` for 4 cycles), then `gnt`=0010.
- Backpressure:
  - Stimulus: during a grant with `q`=5, drive `out_ready`=0 for 3 cycles.
  - Required: `q`=5 and `q_valid`=1 stable; cnt frozen; `d`-changes ignored.
  - On `out_ready`=1, transfers resume and the total per grant is still 4.
- Owner drop:
  - Stimulus: `req[1]` falls mid-burst while `req[3]`=1.
  - Required: same edge `gnt`=1000, `sel`=3; no word taken from `d1` after the drop.
- Async reset mid-burst:
  - Stimulus: assert `rst_n`=0 between edges.
  - Required: `gnt`, `en`, `q_valid` go 0 immediately without a clock.
  - After release with `req`=1111, the first grant is requester 0.
